// File: rtl/mm2s_ram_reader.sv
// Memory-to-stream reader: fetches a contiguous block of RAM words and emits them
// as one AXI-Stream packet, buffered through a small FIFO so reads never overrun it.
module mm2s_ram_reader #(
  parameter  int AXI_WIDTH      = 128,
  parameter  int AXI_ADDR_WIDTH = 32,
  parameter  int LEN_WIDTH      = 32,
  parameter  int FIFO_DEPTH     = 4,
  localparam int LSB            = $clog2(AXI_WIDTH) - 3
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          start,
  input  logic [AXI_ADDR_WIDTH-1:0]     base_addr,
  input  logic [LEN_WIDTH-1:0]          num_bytes,
  output logic                          busy,
  output logic                          done,
  output logic                          mm2s_ren,
  output logic [AXI_ADDR_WIDTH-LSB-1:0] mm2s_addr,
  input  logic [AXI_WIDTH-1:0]          mm2s_data,
  output logic [AXI_WIDTH-1:0]          m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [AXI_WIDTH/8-1:0]        m_axis_tkeep
);

  localparam int BPB = AXI_WIDTH / 8;
  localparam int WAW = AXI_ADDR_WIDTH - LSB;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t               state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ren_q, ren_d;
  logic                 pend_q, pend_d;
  logic                 armed_q, armed_d;
  logic [WAW-1:0]       addr_q, addr_d;
  logic [LEN_WIDTH-1:0] issue_left_q, issue_left_d;
  logic [LEN_WIDTH-1:0] out_left_q, out_left_d;
  logic [BPB-1:0]       keep_last_q, keep_last_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [AXI_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

  logic [LEN_WIDTH-1:0] rem_bytes;
  logic [LEN_WIDTH-1:0] beats;
  logic [BPB-1:0]       keep_new;
  logic                 pop;
  logic                 space;

  always_comb begin
    rem_bytes = num_bytes & LEN_WIDTH'(BPB - 1);
    beats     = (num_bytes >> LSB) + LEN_WIDTH'(rem_bytes != '0);
    keep_new  = '0;
    for (int i = 0; i < BPB; i++) begin
      keep_new[i] = (rem_bytes == '0) || (LEN_WIDTH'(i) < rem_bytes);
    end
  end

  // A slot is reserved for every read still in the RAM pipeline, so a push can never hit a full FIFO.
  assign space = (int'(count_q) + int'(pend_q) + int'(ren_q)) < FIFO_DEPTH;
  assign pop   = m_axis_tvalid && m_axis_tready;

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    ren_d        = 1'b0;
    pend_d       = ren_q;
    armed_d      = 1'b1;
    addr_d       = addr_q;
    issue_left_d = issue_left_q;
    out_left_d   = pop ? out_left_q - LEN_WIDTH'(1) : out_left_q;
    keep_last_d  = keep_last_q;
    wr_ptr_d     = wr_ptr_q + PW'(pend_q);
    rd_ptr_d     = rd_ptr_q + PW'(pop);
    count_d      = count_q + CW'(pend_q) - CW'(pop);

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start && armed_q && !busy_q) begin
          busy_d = 1'b1;
          if (num_bytes == '0) begin
            done_d = 1'b1;
          end else begin
            ren_d        = 1'b1;
            addr_d       = WAW'(base_addr >> LSB);
            issue_left_d = beats - LEN_WIDTH'(1);
            out_left_d   = beats;
            keep_last_d  = keep_new;
            state_d      = (beats == LEN_WIDTH'(1)) ? DRAIN : READ;
          end
        end
      end
      READ: begin
        if (space) begin
          ren_d        = 1'b1;
          addr_d       = addr_q + WAW'(1);
          issue_left_d = issue_left_q - LEN_WIDTH'(1);
          if (issue_left_q == LEN_WIDTH'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && out_left_q == LEN_WIDTH'(1)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ren_q        <= 1'b0;
      pend_q       <= 1'b0;
      armed_q      <= 1'b0;
      addr_q       <= '0;
      issue_left_q <= '0;
      out_left_q   <= '0;
      keep_last_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ren_q        <= ren_d;
      pend_q       <= pend_d;
      armed_q      <= armed_d;
      addr_q       <= addr_d;
      issue_left_q <= issue_left_d;
      out_left_q   <= out_left_d;
      keep_last_q  <= keep_last_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pend_q) fifo_mem[wr_ptr_q] <= mm2s_data;
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign mm2s_ren      = ren_q;
  assign mm2s_addr     = addr_q;
  assign m_axis_tvalid = (count_q != '0);
  assign m_axis_tdata  = fifo_mem[rd_ptr_q];
  assign m_axis_tlast  = m_axis_tvalid && (out_left_q == LEN_WIDTH'(1));

  always_comb begin
    m_axis_tkeep = '0;
    if (m_axis_tvalid) m_axis_tkeep = m_axis_tlast ? keep_last_q : '1;
  end

endmodule

// File: tb/tb_mm2s_ram_reader.sv
// Directed self-checking bench for mm2s_ram_reader: a RAM model answers reads one
// cycle later and a negedge monitor logs reads, stream beats and done pulses.
module tb_mm2s_ram_reader;

  localparam int AW  = 128;
  localparam int ADW = 32;
  localparam int LW  = 32;
  localparam int FD  = 4;
  localparam int WAW = 28;
  localparam int KW  = 16;

  logic            clk;
  logic            rstn;
  logic            start;
  logic [ADW-1:0]  base_addr;
  logic [LW-1:0]   num_bytes;
  logic            busy;
  logic            done;
  logic            mm2s_ren;
  logic [WAW-1:0]  mm2s_addr;
  logic [AW-1:0]   mm2s_data;
  logic [AW-1:0]   m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic            m_axis_tlast;
  logic [KW-1:0]   m_axis_tkeep;

  mm2s_ram_reader #(
    .AXI_WIDTH(AW), .AXI_ADDR_WIDTH(ADW), .LEN_WIDTH(LW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .num_bytes(num_bytes),
    .busy(busy), .done(done), .mm2s_ren(mm2s_ren), .mm2s_addr(mm2s_addr),
    .mm2s_data(mm2s_data), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tkeep(m_axis_tkeep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Every RAM word carries a pattern derived from its own address.
  function automatic logic [AW-1:0] ramWord(input logic [WAW-1:0] a);
    logic [31:0] w;
    w = {4'h0, a};
    return {w ^ 32'hA5A5_0000, ~w, w * 32'd7 + 32'd1, w + 32'h1234_5678};
  endfunction

  always @(posedge clk) begin
    if (mm2s_ren) mm2s_data <= ramWord(mm2s_addr);
  end

  typedef struct {
    logic [AW-1:0] d;
    logic          l;
    logic [KW-1:0] k;
    int            c;
  } beat_t;

  beat_t          beats[$];
  logic [WAW-1:0] raddr[$];
  int             done_count = 0;
  int             done_cyc   = -1;
  logic           done_busy  = 1'bx;
  int             issued     = 0;
  int             popped     = 0;
  int             max_outst  = 0;
  int             stall_err  = 0;
  logic           prev_stall = 1'b0;
  logic [AW-1:0]  prev_d;
  logic           prev_l;
  logic [KW-1:0]  prev_k;

  // Monitor samples mid-cycle; reset wipes its notion of outstanding reads.
  always @(negedge clk) begin
    if (!rstn) begin
      issued     = 0;
      popped     = 0;
      prev_stall = 1'b0;
    end else begin
      if (mm2s_ren) begin
        raddr.push_back(mm2s_addr);
        issued++;
      end
      if (issued - popped > max_outst) max_outst = issued - popped;
      if (prev_stall && (!m_axis_tvalid || m_axis_tdata !== prev_d ||
                         m_axis_tlast !== prev_l || m_axis_tkeep !== prev_k)) stall_err++;
      if (m_axis_tvalid && m_axis_tready) begin
        beats.push_back('{d: m_axis_tdata, l: m_axis_tlast, k: m_axis_tkeep, c: cyc});
        popped++;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_d     = m_axis_tdata;
      prev_l     = m_axis_tlast;
      prev_k     = m_axis_tkeep;
      if (done) begin
        done_count++;
        done_cyc  = cyc;
        done_busy = busy;
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int start_cyc;

  task automatic checkOutput(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t getBeat(input int i);
    beat_t b;
    b = '{d: 'x, l: 1'bx, k: 'x, c: -1};
    if (i < beats.size()) b = beats[i];
    return b;
  endfunction

  function automatic logic [WAW-1:0] getRen(input int i);
    logic [WAW-1:0] a;
    a = 'x;
    if (i < raddr.size()) a = raddr[i];
    return a;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [ADW-1:0] addr, input logic [LW-1:0] nb);
    base_addr = addr;
    num_bytes = nb;
    start     = 1'b1;
    start_cyc = cyc;
    tick();
    start     = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int prev, input int limit, input bit randReady);
    int n;
    n = 0;
    while (done_count == prev && n < limit) begin
      if (randReady) m_axis_tready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    m_axis_tready = 1'b1;
    checkOutput({tag, "_done_seen"}, done_count != prev, 1);
  endtask

  task automatic checkBeats(input string tag, input int b0, input int n,
                            input logic [WAW-1:0] w0, input logic [KW-1:0] lastKeep);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b = getBeat(b0 + i);
      checkOutput($sformatf("%s_beat%0d_data", tag, i), b.d, ramWord(w0 + WAW'(i)));
      checkOutput($sformatf("%s_beat%0d_keep", tag, i), b.k, (i == n - 1) ? lastKeep : 16'hFFFF);
      checkOutput($sformatf("%s_beat%0d_last", tag, i), b.l, (i == n - 1) ? 1'b1 : 1'b0);
    end
  endtask

  initial begin
    int b0, r0, d0;
    rstn          = 1'b0;
    start         = 1'b0;
    base_addr     = '0;
    num_bytes     = '0;
    m_axis_tready = 1'b1;
    repeat (3) tick();

    $display("[TB] reset values");
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_ren", mm2s_ren, 0);
    checkOutput("rst_tvalid", m_axis_tvalid, 0);
    checkOutput("rst_tlast", m_axis_tlast, 0);
    checkOutput("rst_addr", mm2s_addr, 0);
    checkOutput("rst_tkeep", m_axis_tkeep, 0);

    rstn = 1'b1;
    tick();

    $display("[TB] 64 bytes from 0x100, tready high");
    b0 = beats.size(); r0 = raddr.size(); d0 = done_count;
    applyStimulus(32'h100, 64);
    waitDone("t64", d0, 60, 1'b0);
    checkOutput("t64_ren_count", raddr.size() - r0, 4);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("t64_ren_addr%0d", i), getRen(r0 + i), 28'h10 + 28'(i));
    checkOutput("t64_beat_count", beats.size() - b0, 4);
    checkBeats("t64", b0, 4, 28'h10, 16'hFFFF);
    checkOutput("t64_first_latency_le3", (getBeat(b0).c - start_cyc) <= 3, 1);
    for (int i = 1; i < 4; i++) checkOutput($sformatf("t64_b2b%0d", i), getBeat(b0 + i).c, getBeat(b0).c + i);
    checkOutput("t64_done_cycle", done_cyc, getBeat(b0 + 3).c + 1);
    checkOutput("t64_busy_at_done", done_busy, 0);

    $display("[TB] 20 bytes from 0x200");
    b0 = beats.size(); r0 = raddr.size(); d0 = done_count;
    applyStimulus(32'h200, 20);
    waitDone("t20", d0, 40, 1'b0);
    checkOutput("t20_ren_count", raddr.size() - r0, 2);
    checkOutput("t20_beat_count", beats.size() - b0, 2);
    checkBeats("t20", b0, 2, 28'h20, 16'h000F);

    $display("[TB] zero-length transfer and start while busy");
    tick();
    b0 = beats.size(); r0 = raddr.size(); d0 = done_count;
    applyStimulus(32'h300, 0);
    checkOutput("t0_done_next", done, 1);
    checkOutput("t0_busy_next", busy, 1);
    base_addr = 32'h500; num_bytes = 64; start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("t0_done_after", done, 0);
    checkOutput("t0_busy_after", busy, 0);
    repeat (8) tick();
    checkOutput("t0_no_ren", raddr.size() - r0, 0);
    checkOutput("t0_no_beats", beats.size() - b0, 0);
    checkOutput("t0_one_done", done_count - d0, 1);

    $display("[TB] 256 bytes from 0x400, random tready");
    b0 = beats.size(); r0 = raddr.size(); d0 = done_count;
    applyStimulus(32'h400, 256);
    waitDone("t256", d0, 400, 1'b1);
    checkOutput("t256_ren_count", raddr.size() - r0, 16);
    checkOutput("t256_beat_count", beats.size() - b0, 16);
    checkBeats("t256", b0, 16, 28'h40, 16'hFFFF);

    $display("[TB] 160 bytes from 0x800, tready held low 20 cycles");
    b0 = beats.size(); r0 = raddr.size(); d0 = done_count;
    m_axis_tready = 1'b0;
    applyStimulus(32'h800, 160);
    repeat (19) tick();
    checkOutput("t160_stall_ren_count", raddr.size() - r0, 4);
    checkOutput("t160_stall_tvalid", m_axis_tvalid, 1);
    m_axis_tready = 1'b1;
    waitDone("t160", d0, 80, 1'b0);
    checkOutput("t160_beat_count", beats.size() - b0, 10);
    checkBeats("t160", b0, 10, 28'h80, 16'hFFFF);
    checkOutput("max_outstanding_le_depth", max_outst <= FD, 1);
    checkOutput("stall_stability_errors", stall_err, 0);

    $display("[TB] reset mid-transfer, then 32 bytes from 0x40");
    b0 = beats.size(); d0 = done_count;
    applyStimulus(32'h1000, 256);
    for (int n = 0; n < 20 && beats.size() < b0 + 3; n++) tick();
    checkOutput("tr_three_beats_seen", beats.size() >= b0 + 3, 1);
    rstn = 1'b0;
    #1;
    checkOutput("tr_busy", busy, 0);
    checkOutput("tr_done", done, 0);
    checkOutput("tr_ren", mm2s_ren, 0);
    checkOutput("tr_tvalid", m_axis_tvalid, 0);
    checkOutput("tr_tlast", m_axis_tlast, 0);
    checkOutput("tr_tkeep", m_axis_tkeep, 0);
    checkOutput("tr_addr", mm2s_addr, 0);
    repeat (2) tick();
    rstn = 1'b1;
    b0 = beats.size(); r0 = raddr.size(); d0 = done_count;
    tick();
    applyStimulus(32'h40, 32);
    waitDone("tr32", d0, 40, 1'b0);
    repeat (3) tick();
    checkOutput("tr32_ren_count", raddr.size() - r0, 2);
    checkOutput("tr32_beat_count", beats.size() - b0, 2);
    checkOutput("tr32_done_count", done_count - d0, 1);
    checkBeats("tr32", b0, 2, 28'h4, 16'hFFFF);
    checkOutput("final_max_outstanding", max_outst <= FD, 1);
    checkOutput("final_stall_errors", stall_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mm2s_ram_reader.md
MM2S_RAM_READER -- requirements
Module: mm2s_ram_reader

Interface
REQ-001 SHALL have parameter AXI_WIDTH, default 128, RAM/stream data width in bits (multiple of 8, power of 2).
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 32, byte-address width.
REQ-003 SHALL have parameter LEN_WIDTH, default 32, width of the byte-count input.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, output buffer depth in beats (power of 2, at least 2).
REQ-005 SHALL derive local LSB = clog2(AXI_WIDTH)-3.
REQ-006 clk  in  1  single clock, all logic on rising edge.
REQ-007 rstn  in  1  reset, asynchronous, active-low.
REQ-008 start  in  1  one-cycle command strobe.
REQ-009 base_addr  in  AXI_ADDR_WIDTH  byte start address, word-aligned (low LSB bits ignored).
REQ-010 num_bytes  in  LEN_WIDTH  transfer length in bytes.
REQ-011 busy  out  1  high from accepted start until done.
REQ-012 done  out  1  one-cycle pulse after last beat handshaken.
REQ-013 mm2s_ren  out  1  RAM read enable.
REQ-014 mm2s_addr  out  AXI_ADDR_WIDTH-LSB  RAM word address.
REQ-015 mm2s_data  in  AXI_WIDTH  RAM read data, valid exactly 1 cycle after mm2s_ren.
REQ-016 m_axis_tdata/tvalid/tready/tlast/tkeep  out/out/in/out/out  AXI_WIDTH/1/1/1/AXI_WIDTH/8  AXI-Stream master.

Function
REQ-017 SHALL implement states IDLE, READ, DRAIN; IDLE->READ on start with num_bytes>0; READ->DRAIN when final word issued; DRAIN->IDLE when final beat handshaken.
REQ-018 start SHALL be ignored while busy=1.
REQ-019 start with num_bytes=0 SHALL issue no reads, no beats, and pulse done the following cycle with busy held high for that one cycle.
REQ-020 Beat count SHALL be ceil(num_bytes / (AXI_WIDTH/8)); word addresses SHALL be base_addr>>LSB, +1, ... incrementing modulo 2^(AXI_ADDR_WIDTH-LSB).
REQ-021 mm2s_ren SHALL assert in READ only when fifo occupancy + in-flight reads < FIFO_DEPTH; at most one read per cycle.
REQ-022 mm2s_data SHALL be captured into the FIFO on the cycle after mm2s_ren regardless of tready; FIFO SHALL never overflow.
REQ-023 With tready held high, throughput SHALL be one beat per cycle; first tvalid SHALL occur no later than 3 cycles after start.
REQ-024 tvalid SHALL equal FIFO non-empty; tdata/tlast/tkeep SHALL remain stable while tvalid=1 and tready=0.
REQ-025 Beats SHALL be emitted in address order; tlast SHALL be 1 only on the final beat.
REQ-026 tkeep SHALL be all ones except on the final beat, where the low (num_bytes mod AXI_WIDTH/8) bits are set, or all ones if remainder is 0.
REQ-027 done SHALL pulse in the cycle after the tlast handshake; busy SHALL deassert in the same cycle done pulses; a new start SHALL be accepted in that cycle's successor.
REQ-028 Simultaneous FIFO push and pop SHALL leave occupancy unchanged; push when full SHALL be impossible by REQ-021.

Reset
REQ-029 On rstn low, state SHALL go to IDLE immediately; busy, done, mm2s_ren, m_axis_tvalid, m_axis_tlast SHALL be 0; mm2s_addr, tkeep, FIFO pointers and counters SHALL be 0.
REQ-030 Reset mid-transfer SHALL discard all in-flight and buffered data; no beat or done SHALL appear after rstn returns high until a new start.
REQ-031 Deassertion of rstn SHALL take effect synchronously to clk; first start accepted on the second rising edge after rstn high.

Verification
REQ-032 AXI_WIDTH=128, base_addr=0x100, num_bytes=64, tready=1 -> ren addrs 0x10..0x13, 4 beats back-to-back, tkeep=0xFFFF all, tlast on beat 4, done one cycle later.
REQ-033 num_bytes=20 -> 2 beats, beat 2 tkeep=0x000F with tlast=1.
REQ-034 num_bytes=0 -> no ren, no tvalid, done pulse 1 cycle after start.
REQ-035 num_bytes=256, tready random 50% -> 16 beats in order, data matches memory model, never more than FIFO_DEPTH outstanding, tdata stable under stall.
REQ-036 tready=0 for 20 cycles after start, num_bytes=160 -> exactly 4 ren then stall; release tready -> all 10 beats delivered intact.
REQ-037 rstn asserted after beat 3 of a 16-beat transfer -> all outputs 0 immediately; after release, new 32-byte transfer completes with exactly 2 correct beats.
